// File: rtl/multi_port_mem_adapter.sv
// Round-robin arbiter that serialises per-port byte/half/word accesses onto an 8-bit memory bus.
// Optional feature macro: MPMA_SIGN_EXT_EN (sign-extend signed sub-word reads; zero-extend otherwise).

module multi_port_mem_adapter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        flush_pipline,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        rw,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*2-1:0]      size,
    input  logic [NUM_PORTS-1:0]        sgn,
    input  logic [NUM_PORTS*32-1:0]     wdata,
    output logic [NUM_PORTS-1:0]        accepted,
    output logic [NUM_PORTS-1:0]        done,
    output logic [31:0]                 rdata,
    input  logic [7:0]                  mem_din,
    output logic [7:0]                  mem_dout,
    output logic [31:0]                 mem_a,
    output logic                        mem_wr,
    input  logic                        io_buffer_full
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    logic [31:0] addr_arr  [NUM_PORTS];
    logic [1:0]  size_arr  [NUM_PORTS];
    logic [31:0] wdata_arr [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign addr_arr[gi]  = 32'(addr[gi*ADDR_W +: ADDR_W]);
            assign size_arr[gi]  = size[gi*2 +: 2];
            assign wdata_arr[gi] = wdata[gi*32 +: 32];
        end
    endgenerate

    state_t                 state_q;
    logic [IDX_W-1:0]       last_q;
    logic [IDX_W-1:0]       port_q;
    logic [31:0]            addr_q;
    logic [2:0]             nbytes_q;
    logic [31:0]            wdata_q;
    logic [2:0]             cnt_q;
    logic [31:0]            rbuf_q;
    logic [31:0]            rdata_q;
    logic [NUM_PORTS-1:0]   accepted_q;
    logic [NUM_PORTS-1:0]   done_q;
    logic [31:0]            mem_a_q;
    logic [7:0]             mem_dout_q;
    logic                   wr_en_q;

    function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Round-robin: first requester strictly after the last granted index, wrapping.
    logic             grant_found_d;
    logic [IDX_W-1:0] grant_idx_d;
    logic [IDX_W:0]   cand_d;

    always_comb begin
        grant_found_d = 1'b0;
        grant_idx_d   = '0;
        cand_d        = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand_d = {1'b0, last_q} + (IDX_W+1)'(k + 1);
            if (cand_d >= (IDX_W+1)'(NUM_PORTS))
                cand_d = cand_d - (IDX_W+1)'(NUM_PORTS);
            if (!grant_found_d && req[cand_d[IDX_W-1:0]]) begin
                grant_found_d = 1'b1;
                grant_idx_d   = cand_d[IDX_W-1:0];
            end
        end
    end

    // Memory returns byte i one cycle after its address, so cnt_q lags the address by one.
    logic [31:0] rword_d;
    logic [31:0] rdata_d;

    always_comb begin
        rword_d = rbuf_q;
        case (cnt_q)
            3'd1:    rword_d[7:0]   = mem_din;
            3'd2:    rword_d[15:8]  = mem_din;
            3'd3:    rword_d[23:16] = mem_din;
            3'd4:    rword_d[31:24] = mem_din;
            default: ;
        endcase
    end

`ifdef MPMA_SIGN_EXT_EN
    logic sgn_q;

    always_comb begin
        rdata_d = rword_d;
        if (sgn_q && nbytes_q == 3'd1)
            rdata_d = {{24{rword_d[7]}}, rword_d[7:0]};
        else if (sgn_q && nbytes_q == 3'd2)
            rdata_d = {{16{rword_d[15]}}, rword_d[15:0]};
    end
`else
    logic unused_sgn;
    assign unused_sgn = ^sgn;
    assign rdata_d    = rword_d;
`endif

    logic throttle;
    assign throttle = (mem_a_q[17:16] == 2'b11) && io_buffer_full;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            last_q     <= IDX_W'(NUM_PORTS - 1);
            port_q     <= '0;
            addr_q     <= '0;
            nbytes_q   <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rbuf_q     <= '0;
            rdata_q    <= '0;
            accepted_q <= '0;
            done_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            wr_en_q    <= 1'b0;
`ifdef MPMA_SIGN_EXT_EN
            sgn_q      <= 1'b0;
`endif
        end else if (rdy_in) begin
            accepted_q <= '0;
            done_q     <= '0;
            case (state_q)
                IDLE: begin
                    if (!flush_pipline && grant_found_d) begin
                        last_q                  <= grant_idx_d;
                        port_q                  <= grant_idx_d;
                        accepted_q[grant_idx_d] <= 1'b1;
                        addr_q                  <= addr_arr[grant_idx_d];
                        nbytes_q                <= size_to_bytes(size_arr[grant_idx_d]);
                        wdata_q                 <= wdata_arr[grant_idx_d];
                        rbuf_q                  <= '0;
                        cnt_q                   <= '0;
                        mem_a_q                 <= addr_arr[grant_idx_d];
`ifdef MPMA_SIGN_EXT_EN
                        sgn_q                   <= sgn[grant_idx_d];
`endif
                        if (rw[grant_idx_d]) begin
                            state_q    <= WRITE;
                            mem_dout_q <= wdata_arr[grant_idx_d][7:0];
                            wr_en_q    <= 1'b1;
                        end else begin
                            state_q    <= READ;
                        end
                    end
                end
                READ: begin
                    if (flush_pipline) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        mem_a_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q != 3'd0 && cnt_q <= nbytes_q)
                            rbuf_q <= rword_d;
                        mem_a_q <= (cnt_q + 3'd1 < nbytes_q) ? addr_q + 32'(cnt_q) + 32'd1 : 32'd0;
                        if (cnt_q == nbytes_q) begin
                            done_q[port_q] <= 1'b1;
                            rdata_q        <= rdata_d;
                        end
                        if (cnt_q == nbytes_q + 3'd1) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end
                end
                WRITE: begin
                    // Flush is deliberately ignored here: a write in flight always completes.
                    if (cnt_q == nbytes_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (!throttle) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q + 3'd1 == nbytes_q) begin
                            done_q[port_q] <= 1'b1;
                            wr_en_q        <= 1'b0;
                            mem_a_q        <= '0;
                            mem_dout_q     <= '0;
                        end else begin
                            mem_a_q    <= addr_q + 32'(cnt_q) + 32'd1;
                            mem_dout_q <= 8'(wdata_q >> {cnt_q + 3'd1, 3'b000});
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall and IO back-pressure must suppress strobes in the same cycle, hence the gating.
    assign accepted = accepted_q & {NUM_PORTS{rdy_in}};
    assign done     = done_q & {NUM_PORTS{rdy_in}};
    assign mem_wr   = wr_en_q & rdy_in & ~throttle;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign rdata    = rdata_q;

endmodule
